// File: rtl/pattern_scan_ctrl.sv
// Runtime-configurable serial pattern matcher: accepts words over valid/ready,
// shifts them MSB-first through a match window and counts hits.
module pattern_scan_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               word_valid,
  input  logic [WORD_W-1:0]  word_data,
  output logic               word_ready,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_ovf,
  output logic               cfg_err
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, SCAN} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   seen;
  logic [BIT_W-1:0]   bit_idx;
  logic [WORD_W-1:0]  word_q;
  logic               stop_pend;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   seen_inc;
  logic               hit;
  logic               len_ok;
  logic               last_bit;

  // Only the low len bits of the window take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (gi < int'(len_reg));
  end

  // word_q is shifted left as it is consumed, so its MSB is always the next bit.
  assign hist_shift = {hist[MAX_LEN-2:0], word_q[WORD_W-1]};
  assign seen_inc   = (seen < len_reg) ? seen + LEN_W'(1) : seen;
  assign hit        = (seen_inc >= len_reg) &&
                      ((hist_shift & len_mask) == (pattern_reg & len_mask));
  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign last_bit   = (bit_idx == BIT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pattern_reg <= '0;
      len_reg     <= LEN_W'(MAX_LEN);
      overlap_reg <= 1'b1;
      hist        <= '0;
      seen        <= '0;
      bit_idx     <= '0;
      word_q      <= '0;
      stop_pend   <= 1'b0;
      word_ready  <= 1'b0;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
      count_ovf   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err     <= 1'b0;
      match_pulse <= 1'b0;

      if (cfg_we) begin
        if (state == IDLE && len_ok) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ARMED;
            word_ready  <= 1'b1;
            busy        <= 1'b1;
            hist        <= '0;
            seen        <= '0;
            match_count <= '0;
            count_ovf   <= 1'b0;
            stop_pend   <= 1'b0;
          end
        end

        ARMED: begin
          if (stop) begin
            state      <= IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
          end else if (word_valid) begin
            word_q     <= word_data;
            bit_idx    <= '0;
            state      <= SCAN;
            word_ready <= 1'b0;
          end
        end

        SCAN: begin
          hist    <= hist_shift;
          word_q  <= word_q << 1;
          bit_idx <= bit_idx + BIT_W'(1);
          if (hit) begin
            match_pulse <= 1'b1;
            if (match_count == {CNT_W{1'b1}}) begin
              count_ovf <= 1'b1;
            end else begin
              match_count <= match_count + CNT_W'(1);
            end
            seen <= overlap_reg ? seen_inc : '0;
          end else begin
            seen <= seen_inc;
          end
          if (stop) begin
            stop_pend <= 1'b1;
          end
          // A stop arriving on the final bit is honoured just like an earlier one.
          if (last_bit) begin
            if (stop_pend || stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= ARMED;
              word_ready <= 1'b1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          word_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: a bit-history model queues expected
// pulses with their arrival time; a monitor checks every pulse the DUT emits.
module tb_pattern_scan_ctrl;

  localparam int MAX_LEN = 8;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_we;
  logic [7:0]   cfg_pattern;
  logic [3:0]   cfg_len;
  logic         cfg_overlap;
  logic         start;
  logic         stop;
  logic         word_valid;
  logic [7:0]   word_data;
  logic         word_ready;
  logic         busy;
  logic         match_pulse;
  logic [3:0]   match_count;
  logic         count_ovf;
  logic         cfg_err;

  pattern_scan_ctrl #(.MAX_LEN(MAX_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
    .count_ovf(count_ovf), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint t;
    int     cnt;
    bit     ovf;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: configuration plus the list of bits seen since the window last restarted.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         m_ovf;
  bit         m_idle;
  bit         hbits[$];

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic m_bit(input bit b, input longint t);
    bit ok;
    hbits.push_back(b);
    if (hbits.size() > 40) void'(hbits.pop_front());
    if (hbits.size() >= m_len) begin
      ok = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (hbits[hbits.size() - 1 - i] != m_pat[i]) ok = 1'b0;
      if (ok) begin
        if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1'b1;
        else m_cnt++;
        exp_q.push_back('{t, m_cnt, m_ovf});
        if (!m_ovl) hbits.delete();
      end
    end
  endtask

  // Monitor: pops one expectation per pulse; stale expectations are missed pulses.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].t < longint'($time)) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none, required pulse at t=%0d", exp_q[0].t);
      void'(exp_q.pop_front());
    end
    if (match_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_pulse: got match_pulse=1, required 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_time", longint'($time), e.t);
        chk("pulse_count", match_count, e.cnt);
        chk("pulse_ovf", count_ovf, e.ovf);
      end
    end
  end

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    bit bad;
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    @(negedge clk);
    cfg_we = 1'b0;
    bad = !m_idle || l == 0 || l > MAX_LEN;
    chk("cfg_err", cfg_err, bad);
    $display("cfg pattern=%02h len=%0d overlap=%0d rejected=%0d", p, l, o, bad);
    if (!bad) begin
      m_pat = p; m_len = l; m_ovl = o;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_idle = 1'b0; hbits.delete(); m_cnt = 0; m_ovf = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", word_ready, 1);
    chk("start_count", match_count, 0);
    chk("start_ovf", count_ovf, 0);
  endtask

  task automatic do_stop_armed();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    m_idle = 1'b1;
    chk("stop_busy", busy, 0);
    chk("stop_ready", word_ready, 0);
  endtask

  // stop_k / rst_k: raise stop or reset in the cycle that consumes bit k (-1 = never).
  task automatic send_word(input logic [7:0] d, input int stop_k, input int rst_k);
    int n;
    longint t0;
    n = 0;
    while (word_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (word_ready !== 1'b1) begin
      chk("ready_timeout", word_ready, 1);
      return;
    end
    word_valid = 1'b1; word_data = d;
    t0 = longint'($time) + 5;
    for (int k = 0; k < WORD_W; k++)
      if (rst_k < 0 || k < rst_k) m_bit(d[7 - k], t0 + (k + 1) * 10 + 5);
    $display("word %02h accepted at t=%0d, expected count after=%0d", d, t0, m_cnt);
    @(negedge clk);
    word_valid = 1'b0; word_data = 8'($urandom);
    chk("ready_low_in_scan", word_ready, 0);
    for (int j = 0; j < WORD_W; j++) begin
      if (j == stop_k) stop = 1'b1;
      if (j == rst_k) reset = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      if (j == rst_k) begin
        chk("rst_pulse", match_pulse, 0);
        chk("rst_ready", word_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", match_count, 0);
        chk("rst_ovf", count_ovf, 0);
        chk("rst_cfg_err", cfg_err, 0);
        reset = 1'b0;
        m_pat = 8'h00; m_len = MAX_LEN; m_ovl = 1'b1;
        m_idle = 1'b1; hbits.delete(); m_cnt = 0; m_ovf = 1'b0;
        return;
      end
    end
    if (stop_k >= 0) begin
      m_idle = 1'b1;
      chk("stopped_busy", busy, 0);
      chk("stopped_ready", word_ready, 0);
    end else begin
      chk("rearm_ready", word_ready, 1);
      chk("rearm_busy", busy, 1);
    end
    chk("word_count", match_count, m_cnt);
    chk("word_ovf", count_ovf, m_ovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; stop = 1'b0; word_valid = 1'b0; word_data = '0;
    m_pat = 8'h00; m_len = MAX_LEN; m_ovl = 1'b1; m_cnt = 0; m_ovf = 1'b0; m_idle = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", word_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulse", match_pulse, 0);
    chk("reset_count", match_count, 0);
    chk("reset_ovf", count_ovf, 0);
    chk("reset_cfg_err", cfg_err, 0);

    // Overlapping matches at bits 3 and 6.
    do_cfg(8'h0D, 4'd4, 1'b1);
    do_start();
    send_word(8'hDA, -1, -1);
    chk("overlap_count", match_count, 2);
    do_stop_armed();

    // Non-overlapping: single match.
    do_cfg(8'h0D, 4'd4, 1'b0);
    do_start();
    send_word(8'hDA, -1, -1);
    chk("nonoverlap_count", match_count, 1);
    do_stop_armed();

    // Rejected writes leave the old configuration in force.
    do_cfg(8'h0F, 4'd0, 1'b1);
    do_cfg(8'h0F, 4'd9, 1'b1);
    do_start();
    do_cfg(8'h0F, 4'd2, 1'b1);
    send_word(8'hDA, -1, -1);
    chk("old_cfg_count", match_count, 1);
    do_stop_armed();

    // Match straddling a word boundary.
    do_cfg(8'h0D, 4'd4, 1'b1);
    do_start();
    send_word(8'h03, -1, -1);
    send_word(8'h40, -1, -1);
    chk("straddle_count", match_count, 1);
    do_stop_armed();

    // Counter saturation at 2^CNT_W-1 with the sticky overflow.
    do_cfg(8'h01, 4'd1, 1'b1);
    do_start();
    send_word(8'hFF, -1, -1);
    send_word(8'hFF, -1, -1);
    chk("sat_count", match_count, 15);
    chk("sat_ovf", count_ovf, 1);
    do_stop_armed();

    // Stop mid-word: the word completes, then the controller idles.
    do_start();
    send_word(8'hF0, 2, -1);
    repeat (3) @(negedge clk);
    chk("stop_ready_stays_low", word_ready, 0);
    chk("stop_count", match_count, 4);

    // Stop wins over a simultaneous word.
    do_start();
    stop = 1'b1; word_valid = 1'b1; word_data = 8'hFF;
    @(negedge clk);
    stop = 1'b0; word_valid = 1'b0;
    m_idle = 1'b1;
    chk("stop_wins_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("stop_wins_count", match_count, 0);

    // Reset mid-word, then a scan under the reset-default configuration.
    do_start();
    send_word(8'hFF, -1, 2);
    repeat (10) @(negedge clk);
    do_start();
    send_word(8'h00, -1, -1);
    chk("default_cfg_count", match_count, 1);
    do_stop_armed();

    // Randomised configurations and word streams.
    for (int it = 0; it < 25; it++) begin
      int nw;
      do_cfg(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
      do_start();
      nw = $urandom_range(2, 5);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_word(8'($urandom), -1, -1);
      end
      do_stop_armed();
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Programmable controller that accepts parallel words over a valid/ready handshake and serializes them MSB-first through an internal pattern-match window of up to MAX_LEN bits. It holds the match configuration: pattern, length and overlap mode. It counts hits and reports each one as a single-cycle pulse. It sits between the word-oriented capture path and the bit-level detection logic, replacing hard-coded fixed-pattern detectors with one runtime-configurable engine.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- WORD_W, 8, input word width (1..32)
- CNT_W, 8, width of the match counter
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_we  in  1  configuration write strobe
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit in time, bit 0 the last
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length
- cfg_overlap  in  1  1: overlapping matches allowed; 0: window restarts after each match
- start  in  1  pulse: arm the scanner
- stop  in  1  pulse: disarm the scanner
- word_valid  in  1  input word valid
- word_data  in  WORD_W  input word, scanned MSB first
- word_ready  out  1  controller can accept a word
- busy  out  1  state is not IDLE
- match_pulse  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  saturating count of matches since start
- count_ovf  out  1  sticky; set when a match occurs with match_count already at its maximum
- cfg_err  out  1  one-cycle pulse when a configuration write is rejected

## Operation
- States: IDLE, ARMED, SCAN. Internal registers:
  - hist: MAX_LEN-bit shift register of the most recent bits.
  - seen: count of valid bits in the window, saturating at cfg_len.
  - bit_idx: position within the current word.
  - word_q: captured word.
  - stop_pend: deferred stop request.
- IDLE:
  - cfg_we with 1 <= cfg_len <= MAX_LEN loads pattern, len and overlap.
  - Any other cfg_len gives a cfg_err pulse; configuration is unchanged.
  - start: go to ARMED; clear hist, seen, match_count, count_ovf and stop_pend.
- cfg_we in ARMED or SCAN is ignored and gives a cfg_err pulse.
- ARMED:
  - word_ready=1.
  - On word_valid&&word_ready: capture word_data, set bit_idx=0, go to SCAN.
  - stop: go to IDLE, with no word accepted that cycle. If stop and word_valid arrive together, stop wins.
- SCAN:
  - word_ready=0.
  - Each cycle, shift bit word_q[WORD_W-1-bit_idx] into hist[0] (hist <= {hist[MAX_LEN-2:0], b}), increment seen (saturating) and increment bit_idx.
  - Match condition: the updated seen >= len and the updated hist[len-1:0] == pattern[len-1:0].
  - On a match: match_pulse=1, match_count increments (it holds at 2^CNT_W-1 and sets count_ovf instead).
  - On a match with cfg_overlap=0: seen is cleared to 0 instead of incremented.
  - On the last bit (bit_idx==WORD_W-1): go to ARMED, or to IDLE if stop_pend is set.
  - stop during SCAN sets stop_pend. The current word always completes.
- hist and seen persist across words, so matches may straddle word boundaries. They clear only on start or reset.
- start outside IDLE is ignored.
- Reset: state IDLE; all outputs 0; pattern=0, len=MAX_LEN, overlap=1; hist, seen and bit_idx are 0.
- Reset mid-SCAN aborts immediately. The partial word is discarded and no match_pulse is produced.

## Timing
- Handshake at edge E0: SCAN from E0. Bit k is consumed at edge E(k+1).
- match_pulse for bit k is high for exactly the cycle after E(k+1). match_count updates at that same edge.
- State returns to ARMED at E(WORD_W). word_ready is high in the following cycle.
- Maximum throughput is one word per WORD_W+1 cycles.
- cfg_err is registered: high for the cycle after the offending cfg_we edge.
- busy is registered from the state and goes low the cycle after the final bit when stop_pend is set.
- No combinational path from word_valid to word_ready.

## Test plan
- Overlap on, pattern 4'b1101 len 4, word 8'b1101_1010 -> match_pulse after bits 3 and 6 (E4, E7); match_count=2.
- Same word with cfg_overlap=0 -> single pulse at E4; match_count=1.
- Straddle: len 4 pattern 1101; words 8'h03 then 8'h40 -> exactly one pulse, after bit 1 of the second word; count=1.
- Config errors:
  - cfg_len=0 in IDLE -> cfg_err pulse; a following scan uses the old config.
  - cfg_we in ARMED -> cfg_err pulse; no config change.
- Saturation, CNT_W=4: len 1 pattern 1; two words 8'hFF -> 16 pulses; match_count=15; count_ovf=1.
- Stop and reset:
  - stop at bit 2 of a word -> word finishes (remaining pulses still occur); then IDLE; word_ready stays 0.
  - reset at bit 2 -> all outputs 0 next cycle; no further pulses.
